// File: rtl/burst_act_if.sv
// burst_act_if: request, precharge-block and ACT-issue signals between the
// upstream request source (master) and the ACT scheduler (slave).
interface burst_act_if;
    // Upstream request channel
    logic        req_valid;
    logic [1:0]  req_rw;
    logic [2:0]  req_bank;
    logic [15:0] req_row;
    logic        req_ready;

    // Precharge in progress: ACT issue is held off while high
    logic        pre_rdy;

    // ACT issue towards the CAS stage
    logic        act_rdy;
    logic [1:0]  act_rw;
    logic [2:0]  act_bank;
    logic [15:0] act_row;
    logic        act_idle;

    // Request source / precharge side
    modport master (
        output req_valid,
        output req_rw,
        output req_bank,
        output req_row,
        output pre_rdy,
        input  req_ready,
        input  act_rdy,
        input  act_rw,
        input  act_bank,
        input  act_row,
        input  act_idle
    );

    // ACT scheduler side
    modport slave (
        input  req_valid,
        input  req_rw,
        input  req_bank,
        input  req_row,
        input  pre_rdy,
        output req_ready,
        output act_rdy,
        output act_rw,
        output act_bank,
        output act_row,
        output act_idle
    );
endinterface

// File: rtl/burst_act.sv
// burst_act: queues row-activate requests in a small FIFO and issues them as
// one-cycle ACT pulses, spaced by tRRD and blocked while a precharge is in
// progress. Defining BURST_ACT_FAW_EN adds a four-activate-window (tFAW)
// limit built from a ring of four down-counters.
module burst_act #(
    parameter int TRRD   = 4,
    parameter int TFAW   = 20,
    parameter int QDEPTH = 4
) (
    input  logic       clock_t,
    input  logic       reset,
    burst_act_if.slave bus
);

    localparam int               PTR_W    = $clog2(QDEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam int               ENTRY_W  = 2 + 3 + 16;
    localparam logic [1:0]       RW_READ  = 2'b01;
    // The tRRD counter is loaded as the ACT leaves the bus; the next ACT is
    // scheduled in the cycle the counter reads zero and appears one cycle
    // later, giving exactly TRRD cycles between pulses.
    localparam logic [3:0]       RRD_LOAD = 4'(TRRD - 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    // Reject illegal parameter sets at elaboration time
    generate
        if ((TRRD < 3) || (TRRD > 15) || (TFAW < 4 * TRRD) || (TFAW > 63) ||
            (QDEPTH < 2) || (QDEPTH > 8) || ((QDEPTH & (QDEPTH - 1)) != 0)) begin : g_bad_params
            $error("burst_act: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        ACT_IDLE = 2'd0,
        ACT_WAIT = 2'd1,
        ACT_CMD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ENTRY_W-1:0] r_mem [QDEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [ENTRY_W-1:0] w_head;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_issue;
    logic               w_rrd_ok;
    logic               w_faw_ok;

    logic [3:0]         r_rrd_cnt;

    logic [1:0]         r_act_rw;
    logic [2:0]         r_act_bank;
    logic [15:0]        r_act_row;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    // Ready depends only on the registered occupancy, so a pop in the same
    // cycle never lets a full FIFO take a request.
    assign w_ready = (r_count != FULL_CNT);
    assign w_push  = bus.req_valid & w_ready;
    assign w_pop   = (r_state == ACT_CMD);
    assign w_head  = r_mem[r_rd_ptr];

    // Occupancy after this edge's push and pop
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clock_t) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.req_rw, bus.req_bank, bus.req_row};
        end
    end

    // FIFO pointers and occupancy; reset flushes every queued request
    always_ff @(posedge clock_t) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Timing counters
    // ------------------------------------------------------------------
    assign w_rrd_ok = (r_rrd_cnt == 4'd0);

    // tRRD counter: reloads on every ACT, keeps counting through pre_rdy, saturates at zero
    always_ff @(posedge clock_t) begin
        if (reset) begin
            r_rrd_cnt <= 4'd0;
        end else if (w_pop) begin
            r_rrd_cnt <= RRD_LOAD;
        end else if (r_rrd_cnt != 4'd0) begin
            r_rrd_cnt <= r_rrd_cnt - 4'd1;
        end
    end

`ifdef BURST_ACT_FAW_EN
    // Each slot remembers one of the last four ACTs. The slot under the
    // pointer belongs to the fourth-previous ACT, and the next ACT may be
    // scheduled once it has drained to zero.
    localparam logic [5:0] FAW_LOAD = 6'(TFAW - 2);

    logic [1:0] r_faw_ptr;
    logic [3:0] w_faw_zero;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_faw
            logic [5:0] r_faw_cnt;

            // Window counter for one ACT slot, loaded when that slot is reused
            always_ff @(posedge clock_t) begin
                if (reset) begin
                    r_faw_cnt <= 6'd0;
                end else if (w_pop && (r_faw_ptr == 2'(gi))) begin
                    r_faw_cnt <= FAW_LOAD;
                end else if (r_faw_cnt != 6'd0) begin
                    r_faw_cnt <= r_faw_cnt - 6'd1;
                end
            end

            assign w_faw_zero[gi] = (r_faw_cnt == 6'd0);
        end
    endgenerate

    // Ring pointer advances past the slot just loaded by an ACT
    always_ff @(posedge clock_t) begin
        if (reset) begin
            r_faw_ptr <= 2'd0;
        end else if (w_pop) begin
            r_faw_ptr <= r_faw_ptr + 2'd1;
        end
    end

    assign w_faw_ok = w_faw_zero[r_faw_ptr];
`else
    assign w_faw_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    assign w_issue = (r_state == ACT_WAIT) & w_rrd_ok & w_faw_ok & ~bus.pre_rdy;

    // State register
    always_ff @(posedge clock_t) begin
        if (reset) begin
            r_state <= ACT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: ACT_CMD is a single cycle; leave it for ACT_WAIT if
    // anything (including a same-cycle push) is still queued after the pop.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACT_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = ACT_WAIT;
                end
            end
            ACT_WAIT: begin
                if (w_issue) begin
                    w_state_next = ACT_CMD;
                end
            end
            ACT_CMD: begin
                if (w_count_next != '0) begin
                    w_state_next = ACT_WAIT;
                end else begin
                    w_state_next = ACT_IDLE;
                end
            end
            default: w_state_next = ACT_IDLE;
        endcase
    end

    // ACT payload: captured from the FIFO head as ACT_CMD is entered and held afterwards
    always_ff @(posedge clock_t) begin
        if (reset) begin
            r_act_rw   <= RW_READ;
            r_act_bank <= 3'd0;
            r_act_row  <= 16'd0;
        end else if (w_issue) begin
            r_act_rw   <= w_head[20:19];
            r_act_bank <= w_head[18:16];
            r_act_row  <= w_head[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = w_ready;
    assign bus.act_rdy   = (r_state == ACT_CMD);
    assign bus.act_rw    = r_act_rw;
    assign bus.act_bank  = r_act_bank;
    assign bus.act_row   = r_act_row;
    assign bus.act_idle  = (r_state == ACT_IDLE) && (r_count == '0);

endmodule
